// File: rtl/lane_dly_step_ctrl.sv
// lane_dly_step_ctrl
//   Step sequencer for one DDR4 PHY lane. It takes a step command: an optional
//   LOAD, then N MOVE taps on the RX or TX DQS delay line. It emits spaced
//   LOAD/MOVE strobes with DELAY_LINE_SEL/DIRECTION held steady, and brackets
//   them with HS_IO_CLK_PAUSE. It tracks the RX/TX tap positions and aborts on
//   a lane out-of-range flag or when a move would pass a tap bound.
// Ports
//   FAB_CLK, RESET            clock, synchronous active-high reset
//   CMD_*                     command handshake and fields (captured on accept)
//   *_DELAY_LINE_OUT_OF_RANGE lane range flags (sampled on last gap cycle only)
//   DELAY_LINE_*              strobes/levels to the lane controller
//   HS_IO_CLK_PAUSE           pause request around the strobe train
//   BUSY, DONE, DONE_STATUS   progress / completion (status held until next DONE)
//   STEPS_DONE, RX_TAP, TX_TAP  progress counter and tracked tap positions

// Per-line tap tracker; one instance per delay line.
module lane_dly_tap_trk #(
    parameter logic [7:0] TAP_INIT = 8'd1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ld,
    input  logic       mv,
    input  logic       dir,
    output logic [7:0] tap
);
    always_ff @(posedge clk) begin
        if (reset)   tap <= TAP_INIT;
        else if (ld) tap <= TAP_INIT;
        else if (mv) tap <= dir ? tap + 8'd1 : tap - 8'd1;
    end
endmodule

module lane_dly_step_ctrl #(
    parameter int         PAUSE_SETUP = 4,
    parameter int         STEP_GAP    = 3,
    parameter int         PAUSE_HOLD  = 4,
    parameter logic [7:0] TAP_INIT    = 8'd1,
    parameter logic [7:0] TAP_MAX     = 8'd255
) (
    input  logic       FAB_CLK,
    input  logic       RESET,
    input  logic       CMD_VALID,
    output logic       CMD_READY,
    input  logic       CMD_LOAD,
    input  logic       CMD_SEL,
    input  logic       CMD_DIR,
    input  logic [7:0] CMD_STEPS,
    input  logic       RX_DELAY_LINE_OUT_OF_RANGE,
    input  logic       TX_DELAY_LINE_OUT_OF_RANGE,
    output logic       DELAY_LINE_SEL,
    output logic       DELAY_LINE_LOAD,
    output logic       DELAY_LINE_DIRECTION,
    output logic       DELAY_LINE_MOVE,
    output logic       HS_IO_CLK_PAUSE,
    output logic       BUSY,
    output logic       DONE,
    output logic [1:0] DONE_STATUS,
    output logic [7:0] STEPS_DONE,
    output logic [7:0] RX_TAP,
    output logic [7:0] TX_TAP
);
    localparam int NUM_LINES = 2;

    typedef enum logic [2:0] {
        S_IDLE, S_PAUSE_ON, S_STROBE, S_GAP, S_PAUSE_OFF, S_DONE
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       sel_q, sel_d, dir_q, dir_d;
    logic       load_pend_q, load_pend_d;
    logic       cur_load_q, cur_load_d;
    logic [7:0] steps_left_q, steps_left_d;
    logic [7:0] steps_done_d;
    logic [1:0] st_q, st_d;

    logic [NUM_LINES-1:0][7:0] tap;
    logic [7:0] tap_sel, tap_eff;
    logic       oor_sel, tap_ld, tap_mv, go_next;

    assign tap_sel = tap[sel_q];
    assign oor_sel = sel_q ? TX_DELAY_LINE_OUT_OF_RANGE : RX_DELAY_LINE_OUT_OF_RANGE;
    assign RX_TAP  = tap[0];
    assign TX_TAP  = tap[1];

    for (genvar i = 0; i < NUM_LINES; i++) begin : g_line
        lane_dly_tap_trk #(.TAP_INIT(TAP_INIT)) u_trk (
            .clk   (FAB_CLK),
            .reset (RESET),
            .ld    (tap_ld && (sel_q == 1'(i))),
            .mv    (tap_mv && (sel_q == 1'(i))),
            .dir   (dir_q),
            .tap   (tap[i])
        );
    end

    always_ff @(posedge FAB_CLK) begin
        if (RESET) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            sel_q        <= 1'b0;
            dir_q        <= 1'b0;
            load_pend_q  <= 1'b0;
            cur_load_q   <= 1'b0;
            steps_left_q <= '0;
            STEPS_DONE   <= '0;
            st_q         <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            sel_q        <= sel_d;
            dir_q        <= dir_d;
            load_pend_q  <= load_pend_d;
            cur_load_q   <= cur_load_d;
            steps_left_q <= steps_left_d;
            STEPS_DONE   <= steps_done_d;
            st_q         <= st_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        sel_d        = sel_q;
        dir_d        = dir_q;
        load_pend_d  = load_pend_q;
        cur_load_d   = cur_load_q;
        steps_left_d = steps_left_q;
        steps_done_d = STEPS_DONE;
        st_d         = st_q;
        tap_ld       = 1'b0;
        tap_mv       = 1'b0;
        tap_eff      = tap_sel;
        go_next      = 1'b0;

        case (state_q)
            S_IDLE: if (CMD_VALID) begin
                sel_d        = CMD_SEL;
                dir_d        = CMD_DIR;
                load_pend_d  = CMD_LOAD;
                steps_left_d = CMD_STEPS;
                steps_done_d = '0;
                st_d         = 2'b00;
                if (CMD_LOAD || CMD_STEPS != 8'd0) begin
                    state_d = S_PAUSE_ON;
                    cnt_d   = 8'(PAUSE_SETUP - 1);
                end else begin
                    state_d = S_DONE;
                end
            end
            S_PAUSE_ON: begin
                if (cnt_q == 8'd0) go_next = 1'b1;
                else               cnt_d   = cnt_q - 8'd1;
            end
            S_STROBE: begin
                state_d    = S_GAP;
                cnt_d      = 8'(STEP_GAP - 1);
                cur_load_d = load_pend_q;
                if (load_pend_q) load_pend_d  = 1'b0;
                else             steps_left_d = steps_left_q - 8'd1;
            end
            S_GAP: begin
                if (cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end else if (oor_sel) begin
                    state_d = S_PAUSE_OFF;
                    cnt_d   = 8'(PAUSE_HOLD - 1);
                    st_d    = 2'b10;
                end else begin
                    // Commit the strobe; the bound check below must see the
                    // tap as it will be after this edge.
                    if (cur_load_q) begin
                        tap_ld  = 1'b1;
                        tap_eff = TAP_INIT;
                    end else begin
                        tap_mv       = 1'b1;
                        tap_eff      = dir_q ? tap_sel + 8'd1 : tap_sel - 8'd1;
                        steps_done_d = STEPS_DONE + 8'd1;
                    end
                    go_next = 1'b1;
                end
            end
            S_PAUSE_OFF: begin
                if (cnt_q == 8'd0) state_d = S_DONE;
                else               cnt_d   = cnt_q - 8'd1;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Pick the next strobe, or wind down the pause.
        if (go_next) begin
            if (load_pend_q) begin
                state_d = S_STROBE;
            end else if (steps_left_q != 8'd0) begin
                if (dir_q ? (tap_eff == TAP_MAX) : (tap_eff == 8'd0)) begin
                    state_d = S_PAUSE_OFF;
                    cnt_d   = 8'(PAUSE_HOLD - 1);
                    st_d    = 2'b11;
                end else begin
                    state_d = S_STROBE;
                end
            end else begin
                state_d = S_PAUSE_OFF;
                cnt_d   = 8'(PAUSE_HOLD - 1);
            end
        end
    end

    // Outputs are registered from the next state, so they line up with it.
    always_ff @(posedge FAB_CLK) begin
        if (RESET) begin
            CMD_READY            <= 1'b1;
            DELAY_LINE_SEL       <= 1'b0;
            DELAY_LINE_LOAD      <= 1'b0;
            DELAY_LINE_DIRECTION <= 1'b0;
            DELAY_LINE_MOVE      <= 1'b0;
            HS_IO_CLK_PAUSE      <= 1'b0;
            BUSY                 <= 1'b0;
            DONE                 <= 1'b0;
            DONE_STATUS          <= 2'b00;
        end else begin
            CMD_READY            <= (state_d == S_IDLE);
            BUSY                 <= (state_d != S_IDLE);
            DELAY_LINE_SEL       <= (state_d != S_IDLE) && sel_d;
            DELAY_LINE_DIRECTION <= (state_d != S_IDLE) && dir_d;
            DELAY_LINE_LOAD      <= (state_d == S_STROBE) && load_pend_d;
            DELAY_LINE_MOVE      <= (state_d == S_STROBE) && !load_pend_d;
            HS_IO_CLK_PAUSE      <= (state_d == S_PAUSE_ON) || (state_d == S_STROBE) ||
                                    (state_d == S_GAP) || (state_d == S_PAUSE_OFF);
            DONE                 <= (state_d == S_DONE);
            if (state_d == S_DONE) DONE_STATUS <= st_d;
        end
    end
endmodule

// File: tb/tb_lane_dly_step_ctrl.sv
// Directed bench for lane_dly_step_ctrl. Per-cycle output bits are captured
// into vectors indexed by cycle offset from accept, then compared to masks.
module tb_lane_dly_step_ctrl;
    logic       FAB_CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       CMD_VALID = 1'b0, CMD_LOAD = 1'b0, CMD_SEL = 1'b0, CMD_DIR = 1'b0;
    logic [7:0] CMD_STEPS = 8'd0;
    logic       RX_OOR = 1'b0, TX_OOR = 1'b0;
    logic       CMD_READY, DELAY_LINE_SEL, DELAY_LINE_LOAD, DELAY_LINE_DIRECTION;
    logic       DELAY_LINE_MOVE, HS_IO_CLK_PAUSE, BUSY, DONE;
    logic [1:0] DONE_STATUS;
    logic [7:0] STEPS_DONE, RX_TAP, TX_TAP;

    lane_dly_step_ctrl dut (
        .FAB_CLK(FAB_CLK), .RESET(RESET), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
        .CMD_LOAD(CMD_LOAD), .CMD_SEL(CMD_SEL), .CMD_DIR(CMD_DIR), .CMD_STEPS(CMD_STEPS),
        .RX_DELAY_LINE_OUT_OF_RANGE(RX_OOR), .TX_DELAY_LINE_OUT_OF_RANGE(TX_OOR),
        .DELAY_LINE_SEL(DELAY_LINE_SEL), .DELAY_LINE_LOAD(DELAY_LINE_LOAD),
        .DELAY_LINE_DIRECTION(DELAY_LINE_DIRECTION), .DELAY_LINE_MOVE(DELAY_LINE_MOVE),
        .HS_IO_CLK_PAUSE(HS_IO_CLK_PAUSE), .BUSY(BUSY), .DONE(DONE),
        .DONE_STATUS(DONE_STATUS), .STEPS_DONE(STEPS_DONE), .RX_TAP(RX_TAP), .TX_TAP(TX_TAP)
    );

    always #5 FAB_CLK = ~FAB_CLK;

    int tests = 0;
    int fails = 0;
    logic [63:0] v_pause, v_load, v_move, v_done, v_ready, v_sel, v_dir;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] rng(input int lo, input int hi);
        logic [63:0] m;
        m = '0;
        for (int i = lo; i <= hi; i++) m[i] = 1'b1;
        return m;
    endfunction

    // Issue one command, then log 40 cycles. oor_k/rst_k pulse RX OOR / RESET
    // during cycle T+k (0 = never).
    task automatic run(input logic ld, input logic sel, input logic dir, input logic [7:0] steps,
                       input int oor_k, input int rst_k, input logic tx_oor);
        @(negedge FAB_CLK);
        chk("ready_before_cmd", CMD_READY, 1'b1);
        CMD_VALID = 1'b1; CMD_LOAD = ld; CMD_SEL = sel; CMD_DIR = dir; CMD_STEPS = steps;
        TX_OOR = tx_oor;
        @(posedge FAB_CLK);
        v_pause = '0; v_load = '0; v_move = '0; v_done = '0; v_ready = '0; v_sel = '0; v_dir = '0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge FAB_CLK);
            if (k == 1) begin
                // Fields must be ignored once captured.
                CMD_VALID = 1'b0; CMD_LOAD = ~ld; CMD_SEL = ~sel; CMD_DIR = ~dir; CMD_STEPS = ~steps;
            end
            v_pause[k] = HS_IO_CLK_PAUSE;
            v_load[k]  = DELAY_LINE_LOAD;
            v_move[k]  = DELAY_LINE_MOVE;
            v_done[k]  = DONE;
            v_ready[k] = CMD_READY;
            v_sel[k]   = DELAY_LINE_SEL;
            v_dir[k]   = DELAY_LINE_DIRECTION;
            RX_OOR = (k == oor_k);
            RESET  = (k == rst_k);
        end
        RX_OOR = 1'b0;
        TX_OOR = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge FAB_CLK);
        chk("rst_ready", CMD_READY, 1'b1);
        chk("rst_pause", HS_IO_CLK_PAUSE, 1'b0);
        chk("rst_busy", BUSY, 1'b0);
        chk("rst_done", DONE, 1'b0);
        chk("rst_status", DONE_STATUS, 2'b00);
        chk("rst_steps_done", STEPS_DONE, 8'd0);
        chk("rst_rx_tap", RX_TAP, 8'd1);
        chk("rst_tx_tap", TX_TAP, 8'd1);
        RESET = 1'b0;

        // 1: single RX increment; TX OOR held high must be ignored.
        run(1'b0, 1'b0, 1'b1, 8'd1, 0, 0, 1'b1);
        chk("s1_pause", v_pause, rng(1, 12));
        chk("s1_move", v_move, rng(5, 5));
        chk("s1_load", v_load, 64'd0);
        chk("s1_done", v_done, rng(13, 13));
        chk("s1_ready", v_ready, rng(14, 40));
        chk("s1_status", DONE_STATUS, 2'b00);
        chk("s1_rx_tap", RX_TAP, 8'd2);
        chk("s1_tx_tap", TX_TAP, 8'd1);
        chk("s1_steps_done", STEPS_DONE, 8'd1);

        // 2: TX load + 3 increments.
        run(1'b1, 1'b1, 1'b1, 8'd3, 0, 0, 1'b0);
        chk("s2_pause", v_pause, rng(1, 24));
        chk("s2_load", v_load, rng(5, 5));
        chk("s2_move", v_move, rng(9, 9) | rng(13, 13) | rng(17, 17));
        chk("s2_done", v_done, rng(25, 25));
        chk("s2_sel", v_sel, rng(1, 25));
        chk("s2_dir", v_dir, rng(1, 25));
        chk("s2_tx_tap", TX_TAP, 8'd4);
        chk("s2_rx_tap", RX_TAP, 8'd2);
        chk("s2_steps_done", STEPS_DONE, 8'd3);

        @(negedge FAB_CLK); RESET = 1'b1;
        @(negedge FAB_CLK); RESET = 1'b0;
        chk("rst2_rx_tap", RX_TAP, 8'd1);
        chk("rst2_tx_tap", TX_TAP, 8'd1);

        // 3: decrement from 1 hits the lower bound after one move.
        run(1'b0, 1'b0, 1'b0, 8'd5, 0, 0, 1'b0);
        chk("s3_pause", v_pause, rng(1, 12));
        chk("s3_move", v_move, rng(5, 5));
        chk("s3_done", v_done, rng(13, 13));
        chk("s3_status", DONE_STATUS, 2'b11);
        chk("s3_rx_tap", RX_TAP, 8'd0);
        chk("s3_steps_done", STEPS_DONE, 8'd1);

        // 4: RX OOR on the last gap cycle of the 2nd move.
        run(1'b0, 1'b0, 1'b1, 8'd4, 12, 0, 1'b0);
        chk("s4_pause", v_pause, rng(1, 16));
        chk("s4_move", v_move, rng(5, 5) | rng(9, 9));
        chk("s4_done", v_done, rng(17, 17));
        chk("s4_status", DONE_STATUS, 2'b10);
        chk("s4_steps_done", STEPS_DONE, 8'd1);
        chk("s4_rx_tap", RX_TAP, 8'd1);

        // 5: zero-work command.
        run(1'b0, 1'b0, 1'b1, 8'd0, 0, 0, 1'b0);
        chk("s5_done", v_done, rng(1, 1));
        chk("s5_pause", v_pause, 64'd0);
        chk("s5_strobes", v_move | v_load, 64'd0);
        chk("s5_ready", v_ready, rng(2, 40));
        chk("s5_status", DONE_STATUS, 2'b00);
        chk("s5_steps_done", STEPS_DONE, 8'd0);

        // 6: reset mid-command, then a fresh command runs normally.
        run(1'b0, 1'b0, 1'b1, 8'd3, 0, 7, 1'b0);
        chk("s6_pause", v_pause, rng(1, 7));
        chk("s6_move", v_move, rng(5, 5));
        chk("s6_done", v_done, 64'd0);
        chk("s6_ready", v_ready, rng(8, 40));
        chk("s6_rx_tap", RX_TAP, 8'd1);
        chk("s6_tx_tap", TX_TAP, 8'd1);
        run(1'b0, 1'b0, 1'b1, 8'd1, 0, 0, 1'b0);
        chk("s6b_pause", v_pause, rng(1, 12));
        chk("s6b_move", v_move, rng(5, 5));
        chk("s6b_done", v_done, rng(13, 13));
        chk("s6b_rx_tap", RX_TAP, 8'd2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
